// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - parallel word input and serial bit output handshake bundle
// The master drives words in and accepts bits; the slave is the serialiser.
interface piso_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             first;
    logic             last;
    logic             busy;

    modport master (
        output in_data, in_valid, sout_ready,
        input  in_ready, sout, sout_valid, first, last, busy
    );

    modport slave (
        input  in_data, in_valid, sout_ready,
        output in_ready, sout, sout_valid, first, last, busy
    );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out shifter with a one-word holding register
// Words queue in hd while sh is shifting so consecutive words leave with no idle bit.
module piso_stream #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    piso_stream_if.slave   s
);
    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] hd, hd_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hd_full, hd_full_nxt;

    logic sh_valid;
    logic last_bit;
    logic out_bit;
    logic acc_in;
    logic xfer;
    logic done;

    // in_ready depends on registered state only, never on in_valid or sout_ready.
    assign sh_valid = (state == SHIFT);
    assign last_bit = sh_valid && (cnt == CNT_LAST);
    assign out_bit  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign acc_in   = s.in_valid && !hd_full;
    assign xfer     = sh_valid && s.sout_ready;
    assign done     = xfer && last_bit;

    assign s.in_ready   = !hd_full;
    assign s.sout_valid = sh_valid;
    assign s.sout       = sh_valid ? out_bit : IDLE_LEVEL;
    assign s.first      = sh_valid && (cnt == '0);
    assign s.last       = last_bit;
    assign s.busy       = sh_valid || hd_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            hd      <= '0;
            hd_full <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh      <= sh_nxt;
            cnt     <= cnt_nxt;
            hd      <= hd_nxt;
            hd_full <= hd_full_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sh_nxt      = sh;
        cnt_nxt     = cnt;
        hd_nxt      = hd;
        hd_full_nxt = hd_full;

        case (state)
            IDLE: begin
                if (acc_in) begin
                    sh_nxt    = s.in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (done) begin
                    if (hd_full) begin
                        sh_nxt      = hd;
                        cnt_nxt     = '0;
                        hd_full_nxt = 1'b0;
                    end else if (acc_in) begin
                        // End-of-word bypass: the new word goes straight into sh.
                        sh_nxt  = s.in_data;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        sh_nxt  = MSB_FIRST ? (sh << 1) : (sh >> 1);
                        cnt_nxt = cnt + CW'(1);
                    end
                    if (acc_in) begin
                        hd_nxt      = s.in_data;
                        hd_full_nxt = 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule
